// File: rtl/pipe_pkg.sv
// Shared types and width defaults for the pipeline stage registers.
package pipe_pkg;

    typedef struct packed {
        logic mem_to_reg;
        logic pc_src;
        logic reg_write;
        logic mem_write;
        logic valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE    = '0;
    localparam int    DATA_W_DEF     = 32;
    localparam int    REG_ADDR_W_DEF = 4;

endpackage

// File: rtl/pipe_reg_ce_clr.sv
// Generic pipeline register with synchronous reset, clear-to-constant and clock enable.
module pipe_reg_ce_clr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_em_stage.sv
// Execute-to-Memory pipeline register with stall, flush, valid tracking and
// saturating bubble/stall performance counters.
module pipe_em_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_m,
    input  logic                  flush_m,
    input  logic                  valid_e,
    input  logic [DATA_W-1:0]     alu_result_e,
    input  logic [DATA_W-1:0]     write_data_e,
    input  logic [REG_ADDR_W-1:0] wa3_e,
    input  logic                  mem_to_reg_e,
    input  logic                  pc_src_e,
    input  logic                  reg_write_e,
    input  logic                  mem_write_e,
    output logic [DATA_W-1:0]     alu_out_m,
    output logic [DATA_W-1:0]     write_data_m,
    output logic [REG_ADDR_W-1:0] wa3_m,
    output logic                  mem_to_reg_m,
    output logic                  pc_src_m,
    output logic                  reg_write_m,
    output logic                  mem_write_m,
    output logic                  valid_m,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int DW = 2 * DATA_W + REG_ADDR_W;

    logic [DW-1:0] data_d, data_q;
    ctrl_t         ctrl_d, ctrl_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic bubble_inc, stall_inc;

    assign data_d = {alu_result_e, write_data_e, wa3_e};

    // Side-effecting controls are gated so an empty Execute slot can never commit.
    always_comb begin
        ctrl_d            = CTRL_BUBBLE;
        ctrl_d.mem_to_reg = mem_to_reg_e;
        ctrl_d.pc_src     = pc_src_e & valid_e;
        ctrl_d.reg_write  = reg_write_e & valid_e;
        ctrl_d.mem_write  = mem_write_e & valid_e;
        ctrl_d.valid      = valid_e;
    end

    pipe_reg_ce_clr #(
        .W       (DW),
        .CLR_VAL ('0)
    ) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall_m | flush_m),
        .clr   (1'b0),
        .d     (data_d),
        .q     (data_q)
    );

    pipe_reg_ce_clr #(
        .W       ($bits(ctrl_t)),
        .CLR_VAL (CTRL_BUBBLE)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall_m),
        .clr   (flush_m),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    assign bubble_inc = flush_m | (~stall_m & ~valid_e);
    assign stall_inc  = stall_m & ~flush_m;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (bubble_inc && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign {alu_out_m, write_data_m, wa3_m} = data_q;
    assign mem_to_reg_m = ctrl_q.mem_to_reg;
    assign pc_src_m     = ctrl_q.pc_src;
    assign reg_write_m  = ctrl_q.reg_write;
    assign mem_write_m  = ctrl_q.mem_write;
    assign valid_m      = ctrl_q.valid;
    assign bubble_cnt   = bubble_cnt_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_em_stage.sv
// Self-checking bench for pipe_em_stage: directed scenarios plus random traffic against a reference model.
module tb_pipe_em_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_m, flush_m, valid_e;
    logic [31:0] alu_result_e, write_data_e;
    logic [3:0]  wa3_e;
    logic        mem_to_reg_e, pc_src_e, reg_write_e, mem_write_e;

    logic [31:0] alu_out_m, write_data_m;
    logic [3:0]  wa3_m;
    logic        mem_to_reg_m, pc_src_m, reg_write_m, mem_write_m, valid_m;
    logic [15:0] bubble_cnt, stall_cnt;

    logic [31:0] s_alu_out_m, s_write_data_m;
    logic [3:0]  s_wa3_m;
    logic        s_mem_to_reg_m, s_pc_src_m, s_reg_write_m, s_mem_write_m, s_valid_m;
    logic [3:0]  s_bubble_cnt, s_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural view of what the Memory stage holds.
    logic [31:0] m_alu, m_wd;
    logic [3:0]  m_wa3;
    logic        m_m2r, m_pcs, m_rw, m_mw, m_v;
    int          m_bub, m_stl;

    always #5 clk = ~clk;

    pipe_em_stage #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m), .valid_e(valid_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .wa3_e(wa3_e),
        .mem_to_reg_e(mem_to_reg_e), .pc_src_e(pc_src_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e),
        .alu_out_m(alu_out_m), .write_data_m(write_data_m), .wa3_m(wa3_m),
        .mem_to_reg_m(mem_to_reg_m), .pc_src_m(pc_src_m), .reg_write_m(reg_write_m),
        .mem_write_m(mem_write_m), .valid_m(valid_m),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    pipe_em_stage #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall_m(stall_m), .flush_m(flush_m), .valid_e(valid_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .wa3_e(wa3_e),
        .mem_to_reg_e(mem_to_reg_e), .pc_src_e(pc_src_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e),
        .alu_out_m(s_alu_out_m), .write_data_m(s_write_data_m), .wa3_m(s_wa3_m),
        .mem_to_reg_m(s_mem_to_reg_m), .pc_src_m(s_pc_src_m), .reg_write_m(s_reg_write_m),
        .mem_write_m(s_mem_write_m), .valid_m(s_valid_m),
        .bubble_cnt(s_bubble_cnt), .stall_cnt(s_stall_cnt)
    );

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [104:0] dut_vec();
        return {alu_out_m, write_data_m, wa3_m, mem_to_reg_m, pc_src_m, reg_write_m,
                mem_write_m, valid_m, bubble_cnt, stall_cnt};
    endfunction

    function automatic logic [104:0] exp_vec();
        logic [15:0] b, s;
        b = 16'(sat(m_bub, 16));
        s = 16'(sat(m_stl, 16));
        return {m_alu, m_wd, m_wa3, m_m2r, m_pcs, m_rw, m_mw, m_v, b, s};
    endfunction

    // Apply the stage rules for one edge, in priority order reset > flush > stall > load.
    task automatic model_edge();
        if (!rst_n) begin
            {m_alu, m_wd, m_wa3, m_m2r, m_pcs, m_rw, m_mw, m_v} = '0;
            m_bub = 0;
            m_stl = 0;
        end else if (flush_m) begin
            m_alu = alu_result_e;
            m_wd  = write_data_e;
            m_wa3 = wa3_e;
            {m_m2r, m_pcs, m_rw, m_mw, m_v} = '0;
            m_bub++;
        end else if (stall_m) begin
            m_stl++;
        end else begin
            m_alu = alu_result_e;
            m_wd  = write_data_e;
            m_wa3 = wa3_e;
            m_m2r = mem_to_reg_e;
            m_pcs = pc_src_e && valid_e;
            m_rw  = reg_write_e && valid_e;
            m_mw  = mem_write_e && valid_e;
            m_v   = valid_e;
            if (!valid_e) m_bub++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        stall_m = 0; flush_m = 0; valid_e = 0;
        alu_result_e = '0; write_data_e = '0; wa3_e = '0;
        mem_to_reg_e = 0; pc_src_e = 0; reg_write_e = 0; mem_write_e = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wa,
                        input logic rw, input logic mw);
        stall_m = 0; flush_m = 0; valid_e = 1;
        alu_result_e = a; write_data_e = wd; wa3_e = wa;
        mem_to_reg_e = 0; pc_src_e = 0; reg_write_e = rw; mem_write_e = mw;
        tick();
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        tick();
        tick();
        n_cmp++;
        if (dut_vec() !== 105'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", dut_vec());
        end
        rst_n = 1;
        load(32'h0000_00A4, 32'hDEAD_BEEF, 4'h7, 1, 1);
        n_cmp++;
        if ({alu_out_m, write_data_m, wa3_m, reg_write_m, mem_write_m, valid_m}
                !== {32'h0000_00A4, 32'hDEAD_BEEF, 4'h7, 3'b111}) begin
            n_err++;
            $display("FAIL first_load: got %h %h %h rw=%b mw=%b v=%b", alu_out_m, write_data_m,
                     wa3_m, reg_write_m, mem_write_m, valid_m);
        end
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL first_load_model: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        set_idle();
        do_reset();
        load(32'h10, 32'h1, 4'h1, 1, 0);
        stall_m = 1;
        alu_result_e = 32'h20;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (alu_out_m !== 32'h10 || stall_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL stall_hold: got alu=%h cnt=%0d want alu=10 cnt=3", alu_out_m, stall_cnt);
        end
        stall_m = 0;
        tick();
        n_cmp++;
        if (alu_out_m !== 32'h20) begin
            n_err++;
            $display("FAIL stall_release: got %h want 20", alu_out_m);
        end
    endtask

    task automatic test_flush_stall();
        set_idle();
        do_reset();
        load(32'h100, 32'h55, 4'h3, 0, 1);
        n_cmp++;
        if (mem_write_m !== 1'b1 || valid_m !== 1'b1) begin
            n_err++;
            $display("FAIL store_load: got mw=%b v=%b want 1 1", mem_write_m, valid_m);
        end
        flush_m = 1;
        stall_m = 1;
        pc_src_e = 1;
        reg_write_e = 1;
        tick();
        n_cmp++;
        if ({valid_m, mem_write_m, reg_write_m, pc_src_m} !== 4'b0000 ||
                bubble_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL flush_stall: got v/mw/rw/pc=%b%b%b%b bub=%0d stl=%0d want 0000 1 0",
                     valid_m, mem_write_m, reg_write_m, pc_src_m, bubble_cnt, stall_cnt);
        end
    endtask

    task automatic test_invalid_slot();
        set_idle();
        do_reset();
        valid_e = 0; reg_write_e = 1; mem_write_e = 1; pc_src_e = 1;
        alu_result_e = 32'hCAFE;
        tick();
        n_cmp++;
        if ({reg_write_m, mem_write_m, pc_src_m, valid_m} !== 4'b0000 || bubble_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL invalid_slot: got rw/mw/pc/v=%b%b%b%b bub=%0d want 0000 1",
                     reg_write_m, mem_write_m, pc_src_m, valid_m, bubble_cnt);
        end
    endtask

    task automatic test_saturation();
        set_idle();
        do_reset();
        stall_m = 1;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
            n_err++;
            $display("FAIL stall_saturate: got small=%0d wide=%0d want 15 20", s_stall_cnt, stall_cnt);
        end
        tick();
        tick();
        n_cmp++;
        if (s_stall_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL stall_saturate_hold: got %0d want 15", s_stall_cnt);
        end
        do_reset();
        n_cmp++;
        if (s_stall_cnt !== 4'd0 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL saturate_reset: got small=%0d wide=%0d want 0 0", s_stall_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        do_reset();
        load(32'h44, 32'h66, 4'hE, 1, 0);
        stall_m = 1;
        alu_result_e = 32'h99;
        wa3_e = 4'h2;
        tick();
        tick();
        n_cmp++;
        if (wa3_m !== 4'hE) begin
            n_err++;
            $display("FAIL mid_stall_hold: got %h want E", wa3_m);
        end
        rst_n = 0;
        tick();
        n_cmp++;
        if (dut_vec() !== 105'd0) begin
            n_err++;
            $display("FAIL reset_mid_stall: got %h want 0", dut_vec());
        end
        rst_n = 1;
        load(32'h1234_5678, 32'h0BAD_F00D, 4'h9, 1, 1);
        n_cmp++;
        if ({alu_out_m, write_data_m, wa3_m, valid_m} !== {32'h1234_5678, 32'h0BAD_F00D, 4'h9, 1'b1}) begin
            n_err++;
            $display("FAIL post_reset_load: got %h %h %h v=%b", alu_out_m, write_data_m, wa3_m, valid_m);
        end
    endtask

    task automatic test_random();
        set_idle();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 39) != 0);
            flush_m      = ($urandom_range(0, 7) == 0);
            stall_m      = ($urandom_range(0, 3) == 0);
            valid_e      = ($urandom_range(0, 3) != 0);
            alu_result_e = $urandom;
            write_data_e = $urandom;
            wa3_e        = 4'($urandom);
            mem_to_reg_e = 1'($urandom);
            pc_src_e     = 1'($urandom);
            reg_write_e  = 1'($urandom);
            mem_write_e  = 1'($urandom);
            tick();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            n_cmp++;
            if ({s_bubble_cnt, s_stall_cnt} !== {4'(sat(m_bub, 4)), 4'(sat(m_stl, 4))}) begin
                n_err++;
                $display("FAIL random_small_cnt%0d: got bub=%0d stl=%0d want %0d %0d", i,
                         s_bubble_cnt, s_stall_cnt, sat(m_bub, 4), sat(m_stl, 4));
            end
            n_cmp++;
            if (!valid_m && (reg_write_m || mem_write_m || pc_src_m)) begin
                n_err++;
                $display("FAIL invalid_commit%0d: got rw/mw/pc=%b%b%b with valid_m=0", i,
                         reg_write_m, mem_write_m, pc_src_m);
            end
        end
    endtask

    initial begin
        rst_n = 0;
        m_bub = 0;
        m_stl = 0;
        {m_alu, m_wd, m_wa3, m_m2r, m_pcs, m_rw, m_mw, m_v} = '0;
        set_idle();
        #2;
        test_reset();
        test_stall();
        test_flush_stall();
        test_invalid_slot();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_em_stage.md
Name: pipe_em_stage

Overview:
- Parametrised Execute-to-Memory pipeline register for the pipelined ARM core. Successor to the fixed 32-bit EX/MEM latch.
- Adds stall (hold), flush (bubble insertion), a valid bit, and an occupancy/bubble performance counter.
- Sits between the ALU/condition-check stage and the data-memory stage.
- Its control outputs feed the Memory stage and the hazard unit.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_ADDR_W, 4, width of destination register address.
- CNT_W, 16, width of the saturating bubble/stall performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- stall_m  in  1  hold current contents (Memory stage cannot accept).
- flush_m  in  1  load a bubble instead of the Execute values.
- valid_e  in  1  Execute stage holds a real instruction.
- alu_result_e  in  DATA_W  ALU result / memory address.
- write_data_e  in  DATA_W  store data.
- wa3_e  in  REG_ADDR_W  destination register.
- mem_to_reg_e, pc_src_e, reg_write_e, mem_write_e  in  1 each  condition-qualified control.
- alu_out_m  out  DATA_W  registered ALU result.
- write_data_m  out  DATA_W  registered store data.
- wa3_m  out  REG_ADDR_W  registered destination.
- mem_to_reg_m, pc_src_m, reg_write_m, mem_write_m  out  1 each  registered control.
- valid_m  out  1  Memory stage holds a real instruction.
- bubble_cnt  out  CNT_W  cycles in which a bubble was loaded.
- stall_cnt  out  CNT_W  cycles in which the stage was held by stall_m.

Behaviour:
- All state updates on the rising edge of clk only; no combinational path from inputs to outputs; latency exactly 1 cycle.
- Reset (rst_n=0 at an edge), regardless of stall/flush:
  - all outputs go to 0, including data fields, wa3_m, every control bit, valid_m and both counters.
  - Reset mid-stall discards the held instruction.
- Priority at an edge: reset > flush > stall > normal load.
- Flush (flush_m=1):
  - valid_m, reg_write_m, mem_write_m, pc_src_m and mem_to_reg_m load 0.
  - alu_out_m, write_data_m and wa3_m load the Execute values; they are don't-care because the instruction is dead, but load them anyway so nothing needs extra enables.
  - bubble_cnt increments.
  - flush_m together with stall_m is legal: flush wins, and stall_cnt does not increment.
- Stall (stall_m=1, flush_m=0): every output holds its value; stall_cnt increments.
- Normal load (both 0):
  - every output captures its _e counterpart.
  - The control bits reg_write_m, mem_write_m and pc_src_m are ANDed with valid_e, so an invalid Execute slot can never write.
  - valid_m = valid_e.
  - If valid_e=0, bubble_cnt increments (natural bubble).
- Counters saturate at all-ones (2^CNT_W−1) and never wrap.
- Invariant: valid_m=0 implies reg_write_m=mem_write_m=pc_src_m=0 at every cycle after reset.

Decomposition:
- Package pipe_pkg:
  - typedef ctrl_t: packed struct {mem_to_reg, pc_src, reg_write, mem_write, valid}.
  - localparam CTRL_BUBBLE = all-zero ctrl_t.
  - default width constants DATA_W_DEF=32, REG_ADDR_W_DEF=4.
- Sub-module pipe_reg_ce_clr, reused for all pipeline stages:
  - parameters W and CLR_VAL; inputs clk, rst_n, en, clr, d; output q.
  - Semantics: rst_n=0 → q=0; else clr → CLR_VAL; else en → d; else hold.
- Instantiation in pipe_em_stage:
  - the data fields use en=~stall_m|flush_m and clr=0.
  - the control struct uses clr=flush_m and CLR_VAL=CTRL_BUBBLE.
- The counters live in pipe_em_stage.

Test Plan:
1. Reset then load: hold rst_n=0 for 2 edges, then drive valid_e=1, alu_result_e=0x0000_00A4, write_data_e=0xDEAD_BEEF, wa3_e=4'h7, reg_write_e=1, mem_write_e=1 → after 1 edge, outputs mirror these values and valid_m=1; before that edge, all outputs are 0.
2. Stall hold: after load of alu_result_e=0x10, assert stall_m for 3 cycles while the inputs change to 0x20 → alu_out_m stays 0x10 and stall_cnt=3. Deassert stall_m → alu_out_m=0x20 on the next edge.
3. Flush with stall: load a valid store (mem_write_e=1), then assert flush_m=1 and stall_m=1 together → next edge valid_m=0, mem_write_m=0, reg_write_m=0, pc_src_m=0, bubble_cnt=1, stall_cnt unchanged.
4. Invalid slot gating: valid_e=0 with reg_write_e=1 and mem_write_e=1 → reg_write_m=0, mem_write_m=0, valid_m=0, bubble_cnt increments by 1.
5. Counter saturation with CNT_W=4: 20 consecutive stall cycles → stall_cnt reads 15 and holds 15. A reset then returns it to 0.
6. Reset mid-stall: stall_m=1 holding wa3_m=4'hE, then rst_n=0 for 1 edge → all outputs 0; with rst_n=1 and stall released, the next edge loads fresh Execute values.
